// File: rtl/copperv_pkg.sv
// Shared bus widths and arbiter types for the copperv memory side.
package copperv_pkg;

  localparam int unsigned bus_width = 32;
  localparam int unsigned sel_width = bus_width / 8;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_e;

  typedef enum logic {
    ARB_INST,
    ARB_DATA
  } arb_port_e;

  // Request fields held while a port waits for (or owns) the memory port.
  typedef struct packed {
    logic [bus_width-1:0] adr;
    logic                 we;
    logic [sel_width-1:0] sel;
    logic [bus_width-1:0] datwr;
  } wb_req_t;

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone signal bundle used by the copperv masters and the memory slave.
interface wishbone_if;
  logic                                 cyc;
  logic                                 stb;
  logic                                 we;
  logic [copperv_pkg::bus_width-1:0]    adr;
  logic [copperv_pkg::sel_width-1:0]    sel;
  logic [copperv_pkg::bus_width-1:0]    datwr;
  logic [copperv_pkg::bus_width-1:0]    datrd;
  logic                                 ack;

  modport master (
    output cyc, stb, we, adr, sel, datwr,
    input  ack, datrd
  );

  modport slave (
    input  cyc, stb, we, adr, sel, datwr,
    output ack, datrd
  );
endinterface

// File: rtl/wb_req_buffer.sv
// Per-port request capture: latches a strobed request and holds it pending until acked.
module wb_req_buffer
  import copperv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    stb,
  input  wb_req_t bus_req,
  input  logic    ack,
  output logic    pend,
  output wb_req_t req
);

  logic    pend_q, pend_d;
  wb_req_t req_q, req_d;
  logic    capture;

  // A new request may land on the same edge the previous one is acked.
  assign capture = stb && (!pend_q || ack);

  always_comb begin
    pend_d = pend_q;
    req_d  = req_q;
    if (capture) begin
      pend_d = 1'b1;
      req_d  = bus_req;
    end else if (ack) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  assign pend = pend_q;
  assign req  = req_q;

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between instruction and data masters.
// Optional forced release of stalled transfers is enabled with WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import copperv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  wishbone_if.slave  inst_if,
  wishbone_if.slave  data_if,
  wishbone_if.master mem_if,
  output logic       timeout_flag
);

  arb_state_e state_q, state_d;
  arb_port_e  last_gnt_q, last_gnt_d;

  logic    pend_inst, pend_data;
  wb_req_t bus_inst, bus_data;
  wb_req_t req_inst, req_data, mem_req;
  logic    ack_inst, ack_data;
  logic    forced;
  logic    done;

  assign bus_inst = '{adr: inst_if.adr, we: inst_if.we, sel: inst_if.sel, datwr: inst_if.datwr};
  assign bus_data = '{adr: data_if.adr, we: data_if.we, sel: data_if.sel, datwr: data_if.datwr};

  wb_req_buffer u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .stb     (inst_if.stb),
    .bus_req (bus_inst),
    .ack     (ack_inst),
    .pend    (pend_inst),
    .req     (req_inst)
  );

  wb_req_buffer u_data_buf (
    .clk     (clk),
    .rst     (rst),
    .stb     (data_if.stb),
    .bus_req (bus_data),
    .ack     (ack_data),
    .pend    (pend_data),
    .req     (req_data)
  );

  // A transfer finishes on a real ack or on a forced timeout release.
  assign done = mem_if.ack || forced;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (pend_inst && (!pend_data || last_gnt_q == ARB_DATA)) begin
          state_d = GNT_I;
        end else if (pend_data) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (done) begin
          last_gnt_d = ARB_INST;
          state_d    = pend_data ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (done) begin
          last_gnt_d = ARB_DATA;
          state_d    = pend_inst ? GNT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= ARB_DATA;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Idle still drives the inst request so the address bus never floats to X.
  assign mem_req      = (state_q == GNT_D) ? req_data : req_inst;
  assign mem_if.cyc   = (state_q != IDLE);
  assign mem_if.stb   = (state_q != IDLE);
  assign mem_if.adr   = mem_req.adr;
  assign mem_if.we    = mem_req.we;
  assign mem_if.sel   = mem_req.sel;
  assign mem_if.datwr = mem_req.datwr;

  // An ack arriving while reset is asserted belongs to an abandoned transfer.
  assign ack_inst = (state_q == GNT_I) && done && !rst;
  assign ack_data = (state_q == GNT_D) && done && !rst;

  assign inst_if.ack   = ack_inst;
  assign data_if.ack   = ack_data;
  assign inst_if.datrd = forced ? '0 : mem_if.datrd;
  assign data_if.datrd = forced ? '0 : mem_if.datrd;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 flag_q;

  // Any state change is either a grant entry or a release, so both restart the count.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (state_q != IDLE && !mem_if.ack) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign forced = (state_q != IDLE) && !mem_if.ack &&
                  (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (forced) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = flag_q;
`else
  logic [TIMEOUT_W-1:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
  assign forced             = 1'b0;
  assign timeout_flag       = 1'b0;
`endif

  // Slave-side cyc is not a request qualifier; stb alone is.
  logic unused_cyc;
  assign unused_cyc = inst_if.cyc | data_if.cyc;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed and randomized bench for wb_mem_arbiter with a scoreboard memory model.
module tb_wb_mem_arbiter;
  import copperv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic timeout_flag;

  wishbone_if inst_bus ();
  wishbone_if data_bus ();
  wishbone_if mem_bus ();

  wb_mem_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_if      (inst_bus),
    .data_if      (data_bus),
    .mem_if       (mem_bus),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_model [0:127];
  wb_req_t     exp_req [2];
  bit          outst [2];
  int          issue_cyc [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drop_stb();
    inst_bus.cyc = 1'b0;
    inst_bus.stb = 1'b0;
    data_bus.cyc = 1'b0;
    data_bus.stb = 1'b0;
  endtask

  task automatic clear_inputs();
    drop_stb();
    inst_bus.we = 1'b0; inst_bus.adr = '0; inst_bus.sel = '0; inst_bus.datwr = '0;
    data_bus.we = 1'b0; data_bus.adr = '0; data_bus.sel = '0; data_bus.datwr = '0;
    mem_bus.ack = 1'b0;
    mem_bus.datrd = '0;
  endtask

  task automatic drive_inst(input logic [31:0] adr);
    inst_bus.cyc = 1'b1; inst_bus.stb = 1'b1; inst_bus.we = 1'b0;
    inst_bus.adr = adr; inst_bus.sel = 4'hf; inst_bus.datwr = '0;
  endtask

  task automatic drive_data(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] datwr);
    data_bus.cyc = 1'b1; data_bus.stb = 1'b1; data_bus.we = we;
    data_bus.adr = adr; data_bus.sel = sel; data_bus.datwr = datwr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    settle();
    chk("rst_cyc", mem_bus.cyc, 1'b0);
    chk("rst_stb", mem_bus.stb, 1'b0);
    chk("rst_inst_ack", inst_bus.ack, 1'b0);
    chk("rst_data_ack", data_bus.ack, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n_inst, n_data, n_xfer, got, own, idx, exp_next;
    int wait_cnt;
    bit rereq_i, rereq_d;

    // Inst-only fetch: stb at cycle 0, memory stb at cycle 2, same-cycle ack.
    do_reset();
    chk("rst_tmo_flag", timeout_flag, 1'b0);
    drive_inst(32'h100);
    settle();
    chk("t1_c0_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); drop_stb(); settle();
    chk("t1_c1_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); mem_bus.ack = 1'b1; mem_bus.datrd = 32'h00500093; settle();
    chk("t1_c2_stb", mem_bus.stb, 1'b1);
    chk("t1_c2_adr", mem_bus.adr, 32'h100);
    chk("t1_c2_we", mem_bus.we, 1'b0);
    chk("t1_inst_ack", inst_bus.ack, 1'b1);
    chk("t1_inst_datrd", inst_bus.datrd, 32'h00500093);
    chk("t1_data_ack", data_bus.ack, 1'b0);
    next_cycle(); mem_bus.ack = 1'b0; settle();
    chk("t1_c3_cyc", mem_bus.cyc, 1'b0);

    // Simultaneous requests after reset: inst first, data back-to-back.
    do_reset();
    drive_inst(32'h200);
    drive_data(32'h1004, 1'b1, 4'b0011, 32'hABCD);
    settle();
    next_cycle(); drop_stb(); settle();
    chk("t2_c1_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); mem_bus.ack = 1'b1; mem_bus.datrd = 32'h11111111; settle();
    chk("t2_i_adr", mem_bus.adr, 32'h200);
    chk("t2_i_we", mem_bus.we, 1'b0);
    chk("t2_i_ack", inst_bus.ack, 1'b1);
    chk("t2_i_dack", data_bus.ack, 1'b0);
    next_cycle(); settle();
    chk("t2_d_cyc", mem_bus.cyc, 1'b1);
    chk("t2_d_req", {mem_bus.adr, mem_bus.we, mem_bus.sel, mem_bus.datwr},
        {32'h1004, 1'b1, 4'b0011, 32'h0000ABCD});
    chk("t2_d_ack", data_bus.ack, 1'b1);
    chk("t2_d_iack", inst_bus.ack, 1'b0);
    next_cycle(); mem_bus.ack = 1'b0; settle();
    chk("t2_end_cyc", mem_bus.cyc, 1'b0);

    // Fairness: both masters keep re-requesting; memory acks whenever asked.
    n_inst = 0; n_data = 0; n_xfer = 0;
    rereq_i = 1'b1; rereq_d = 1'b1;
    for (int c = 0; c < 80 && n_xfer < 10; c++) begin
      next_cycle();
      drop_stb();
      if (rereq_i) drive_inst(32'h300 + 32'(n_inst) * 4);
      if (rereq_d) drive_data(32'h1100 + 32'(n_data) * 4, 1'b0, 4'hf, 32'h0);
      rereq_i = 1'b0; rereq_d = 1'b0;
      mem_bus.ack = 1'b1;
      settle();
      if (inst_bus.ack || data_bus.ack) begin
        got = data_bus.ack ? 1 : 0;
        chk("t3_owner", got, n_xfer % 2);
        chk("t3_excl", inst_bus.ack & data_bus.ack, 1'b0);
        if (got == 0) begin
          chk("t3_i_adr", mem_bus.adr, 32'h300 + 32'(n_inst) * 4);
          n_inst++;
          rereq_i = (n_inst < 5);
        end else begin
          chk("t3_d_adr", mem_bus.adr, 32'h1100 + 32'(n_data) * 4);
          n_data++;
          rereq_d = (n_data < 5);
        end
        n_xfer++;
      end
    end
    chk("t3_n_inst", n_inst, 5);
    chk("t3_n_data", n_data, 5);

    // Capture-on-ack: new data stb in the cycle its previous ack returns.
    next_cycle(); clear_inputs(); drive_data(32'h1F00, 1'b0, 4'hf, 32'h0); settle();
    next_cycle(); drop_stb(); settle();
    next_cycle(); mem_bus.ack = 1'b1; mem_bus.datrd = 32'hCAFE0001;
    drive_data(32'h2000, 1'b0, 4'hf, 32'h0); settle();
    chk("t4_first_adr", mem_bus.adr, 32'h1F00);
    chk("t4_first_ack", data_bus.ack, 1'b1);
    chk("t4_first_datrd", data_bus.datrd, 32'hCAFE0001);
    next_cycle(); drop_stb(); mem_bus.ack = 1'b0; settle();
    chk("t4_gap_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); mem_bus.ack = 1'b1; mem_bus.datrd = 32'h2; settle();
    chk("t4_second_cyc", mem_bus.cyc, 1'b1);
    chk("t4_second_adr", mem_bus.adr, 32'h2000);
    chk("t4_second_ack", data_bus.ack, 1'b1);
    next_cycle(); mem_bus.ack = 1'b0; settle();
    chk("t4_end_cyc", mem_bus.cyc, 1'b0);

    // Reset in the middle of a granted data transfer.
    next_cycle(); drive_data(32'h3000, 1'b0, 4'hf, 32'h0); settle();
    next_cycle(); drop_stb(); settle();
    next_cycle(); settle();
    chk("t5_gnt_cyc", mem_bus.cyc, 1'b1);
    chk("t5_gnt_adr", mem_bus.adr, 32'h3000);
    next_cycle(); rst = 1'b1; mem_bus.ack = 1'b1; settle();
    chk("t5_rst_dack", data_bus.ack, 1'b0);
    next_cycle(); rst = 1'b0; settle();
    chk("t5_post_cyc", mem_bus.cyc, 1'b0);
    chk("t5_late_dack", data_bus.ack, 1'b0);
    chk("t5_late_iack", inst_bus.ack, 1'b0);
    next_cycle(); mem_bus.ack = 1'b0; settle();
    chk("t5_idle1_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); settle();
    chk("t5_idle2_cyc", mem_bus.cyc, 1'b0);

    // Randomized traffic against a memory model; inst uses 0x000-0x0FC, data 0x100-0x1FC.
    for (int i = 0; i < 128; i++) mem_model[i] = $urandom;
    outst[0] = 1'b0; outst[1] = 1'b0;
    wait_cnt = $urandom_range(3);
    exp_next = -1;
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      drop_stb();
      mem_bus.ack = 1'b0;
      if (mem_bus.cyc) begin
        if (wait_cnt == 0) begin
          mem_bus.ack = 1'b1;
          mem_bus.datrd = mem_model[mem_bus.adr[8:2]];
        end else begin
          wait_cnt--;
        end
      end
      if (c < 500) begin
        if (!outst[0] && $urandom_range(2) == 0) begin
          exp_req[0] = '{adr: 32'($urandom_range(63)) << 2, we: 1'b0, sel: 4'hf, datwr: '0};
          drive_inst(exp_req[0].adr);
          outst[0] = 1'b1; issue_cyc[0] = c;
        end
        if (!outst[1] && $urandom_range(2) == 0) begin
          exp_req[1] = '{adr: 32'h100 | (32'($urandom_range(63)) << 2),
                         we: 1'($urandom_range(1)), sel: 4'($urandom_range(15, 1)),
                         datwr: $urandom};
          drive_data(exp_req[1].adr, exp_req[1].we, exp_req[1].sel, exp_req[1].datwr);
          outst[1] = 1'b1; issue_cyc[1] = c;
        end
      end
      settle();
      if (exp_next >= 0) begin
        chk("rnd_b2b_cyc", mem_bus.cyc, 1'b1);
        chk("rnd_b2b_owner", mem_bus.adr[8], exp_next);
        exp_next = -1;
      end
      if (mem_bus.cyc) begin
        own = mem_bus.adr[8] ? 1 : 0;
        chk("rnd_owner_pend", outst[own], 1'b1);
        chk("rnd_req", {mem_bus.adr, mem_bus.we, mem_bus.sel, mem_bus.datwr}, exp_req[own]);
        if (mem_bus.ack) begin
          chk("rnd_ack_owner", own ? data_bus.ack : inst_bus.ack, 1'b1);
          chk("rnd_ack_other", own ? inst_bus.ack : data_bus.ack, 1'b0);
          idx = int'(exp_req[own].adr[8:2]);
          if (!exp_req[own].we) begin
            chk("rnd_datrd", own ? data_bus.datrd : inst_bus.datrd, mem_model[idx]);
          end else begin
            for (int b = 0; b < 4; b++)
              if (exp_req[own].sel[b]) mem_model[idx][8*b +: 8] = exp_req[own].datwr[8*b +: 8];
          end
          outst[own] = 1'b0;
          wait_cnt = $urandom_range(3);
          if (outst[1-own] && issue_cyc[1-own] < c) exp_next = 1 - own;
        end else begin
          chk("rnd_noack_i", inst_bus.ack, 1'b0);
          chk("rnd_noack_d", data_bus.ack, 1'b0);
        end
      end
    end
    chk("rnd_drain_i", outst[0], 1'b0);
    chk("rnd_drain_d", outst[1], 1'b0);
    chk("rnd_tmo_flag", timeout_flag, 1'b0);

    next_cycle(); clear_inputs();
    drive_data(32'h1180, 1'b0, 4'hf, 32'h0); settle();
    next_cycle(); drop_stb(); mem_bus.datrd = 32'hDEADBEEF; settle();
`ifdef WB_ARB_TIMEOUT_EN
    // Silent memory: synthetic data ack 8 cycles after grant, datrd forced to zero.
    for (int k = 0; k < 8; k++) begin
      next_cycle(); settle();
      chk("t6_wait_cyc", mem_bus.cyc, 1'b1);
      chk("t6_wait_dack", data_bus.ack, 1'b0);
    end
    next_cycle(); settle();
    chk("t6_tmo_dack", data_bus.ack, 1'b1);
    chk("t6_tmo_datrd", data_bus.datrd, 32'h0);
    chk("t6_tmo_iack", inst_bus.ack, 1'b0);
    next_cycle(); drive_inst(32'h40); settle();
    chk("t6_flag", timeout_flag, 1'b1);
    chk("t6_rel_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); drop_stb(); settle();
    chk("t6_i_wait_cyc", mem_bus.cyc, 1'b0);
    next_cycle(); mem_bus.ack = 1'b1; mem_bus.datrd = 32'h13; settle();
    chk("t6_i_adr", mem_bus.adr, 32'h40);
    chk("t6_i_ack", inst_bus.ack, 1'b1);
    chk("t6_i_datrd", inst_bus.datrd, 32'h13);
    next_cycle(); mem_bus.ack = 1'b0; settle();
    chk("t6_flag_sticky", timeout_flag, 1'b1);
`else
    // Silent memory without forced release: the grant is held indefinitely.
    for (int k = 0; k < 20; k++) begin
      next_cycle(); settle();
      chk("t6_hold_cyc", mem_bus.cyc, 1'b1);
      chk("t6_hold_dack", data_bus.ack, 1'b0);
    end
    next_cycle(); mem_bus.ack = 1'b1; mem_bus.datrd = 32'h77; settle();
    chk("t6_late_dack", data_bus.ack, 1'b1);
    chk("t6_late_datrd", data_bus.datrd, 32'h77);
    next_cycle(); mem_bus.ack = 1'b0; settle();
    chk("t6_end_cyc", mem_bus.cyc, 1'b0);
    chk("t6_flag_zero", timeout_flag, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
